// File: rtl/tone_sequencer.sv
// Multi-voice square-wave song player driven from an internal synchronous-read song memory.
// Optional macro TONE_SEQ_MIX_EN replaces the voice-0 passthrough on audio_mix with a sigma-delta mixer.
module tone_sequencer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 16,
  parameter int VOICES   = 2,
  parameter int PERIOD_W = 20,
  parameter int ADDR_W   = 8,
  localparam int ENTRY_W = 1 + 5 + VOICES * PERIOD_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                play,
  input  logic                loop_en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0]  wr_data,
  output logic                busy,
  output logic [ADDR_W-1:0]   step_index,
  output logic                done,
  output logic [VOICES-1:0]   audio_out,
  output logic                audio_mix,
  output logic                aud_sd
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, HOLD} state_t;

  state_t                            state;
  logic                              fetch_phase;
  logic [ADDR_W-1:0]                 addr;
  logic [ENTRY_W-1:0]                mem [2**ADDR_W];
  logic [ENTRY_W-1:0]                mem_q;
  logic                              fetch_end;
  logic [4:0]                        fetch_dur;
  logic [VOICES-1:0][PERIOD_W-1:0]   fetch_half;
  logic                              note_end;
  logic [4:0]                        note_dur;
  logic [VOICES-1:0][PERIOD_W-1:0]   half_q;
  logic [VOICES-1:0][PERIOD_W-1:0]   voice_cnt;
  logic [TICK_W-1:0]                 tick_cnt;
  logic [4:0]                        beat_cnt;

  assign aud_sd     = 1'b1;
  assign step_index = addr;

  // The read port always follows addr; a write in the same cycle lands after the read, so old data is returned.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    mem_q <= mem[addr];
  end

  assign fetch_end  = mem_q[ENTRY_W-1];
  assign fetch_dur  = mem_q[ENTRY_W-2 -: 5];
  assign fetch_half = mem_q[VOICES*PERIOD_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      fetch_phase <= 1'b0;
      addr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      audio_out   <= '0;
      note_end    <= 1'b0;
      note_dur    <= '0;
      half_q      <= '0;
      voice_cnt   <= '0;
      tick_cnt    <= '0;
      beat_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (!play) begin
        state       <= IDLE;
        fetch_phase <= 1'b0;
        addr        <= '0;
        busy        <= 1'b0;
        audio_out   <= '0;
        voice_cnt   <= '0;
        tick_cnt    <= '0;
        beat_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state       <= FETCH;
            fetch_phase <= 1'b0;
            addr        <= '0;
            busy        <= 1'b1;
          end
          FETCH: begin
            if (!fetch_phase) begin
              fetch_phase <= 1'b1;
            end else begin
              fetch_phase <= 1'b0;
              if (fetch_dur != 5'd0) begin
                state     <= PLAY;
                note_end  <= fetch_end;
                note_dur  <= fetch_dur;
                half_q    <= fetch_half;
                voice_cnt <= '0;
                tick_cnt  <= '0;
                beat_cnt  <= '0;
                audio_out <= '0;
              end else if (!fetch_end) begin
                addr <= addr + ADDR_W'(1);
              end else if (loop_en) begin
                addr <= '0;
              end else begin
                state     <= HOLD;
                busy      <= 1'b0;
                done      <= 1'b1;
                audio_out <= '0;
              end
            end
          end
          PLAY: begin
            for (int v = 0; v < VOICES; v++) begin
              if (half_q[v] == '0) begin
                voice_cnt[v] <= '0;
                audio_out[v] <= 1'b0;
              end else if (voice_cnt[v] == half_q[v] - PERIOD_W'(1)) begin
                voice_cnt[v] <= '0;
                audio_out[v] <= ~audio_out[v];
              end else begin
                voice_cnt[v] <= voice_cnt[v] + PERIOD_W'(1);
              end
            end
            // Expiry overrides the voice updates above, so a final silence wins over a last toggle.
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              beat_cnt <= beat_cnt + 5'd1;
              if (beat_cnt == note_dur - 5'd1) begin
                fetch_phase <= 1'b0;
                if (!note_end) begin
                  state <= FETCH;
                  addr  <= addr + ADDR_W'(1);
                end else if (loop_en) begin
                  state <= FETCH;
                  addr  <= '0;
                end else begin
                  state     <= HOLD;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  audio_out <= '0;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          HOLD: begin
            busy <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef TONE_SEQ_MIX_EN
  localparam int MIX_W = $clog2(VOICES) + 1;

  logic [MIX_W-1:0] active_cnt;
  logic [MIX_W-1:0] mix_acc;
  logic [MIX_W-1:0] mix_sum;

  always_comb begin
    active_cnt = '0;
    for (int v = 0; v < VOICES; v++) begin
      active_cnt = active_cnt + MIX_W'(audio_out[v]);
    end
    mix_sum = mix_acc + active_cnt;
  end

  // First-order sigma-delta: emit a 1 whenever the accumulated voice count reaches VOICES.
  always_ff @(posedge clock) begin
    if (reset) begin
      mix_acc   <= '0;
      audio_mix <= 1'b0;
    end else if (mix_sum >= MIX_W'(VOICES)) begin
      mix_acc   <= mix_sum - MIX_W'(VOICES);
      audio_mix <= 1'b1;
    end else begin
      mix_acc   <= mix_sum;
      audio_mix <= 1'b0;
    end
  end
`else
  assign audio_mix = audio_out[0];
`endif

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at 100 clocks per tick, two 8-bit voices.
module tb_tone_sequencer;

  localparam int CLK_HZ   = 1600;
  localparam int TICK_HZ  = 16;
  localparam int VOICES   = 2;
  localparam int PERIOD_W = 8;
  localparam int ADDR_W   = 8;
  localparam int ENTRY_W  = 1 + 5 + VOICES * PERIOD_W;

  logic                clock = 1'b0;
  logic                reset;
  logic                play;
  logic                loop_en;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ENTRY_W-1:0]  wr_data;
  logic                busy;
  logic [ADDR_W-1:0]   step_index;
  logic                done;
  logic [VOICES-1:0]   audio_out;
  logic                audio_mix;
  logic                aud_sd;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_no      = 0;

  typedef struct {
    int         edge_no;
    logic       play;
    logic       loop_en;
    logic       exp_busy;
    int         exp_step;
    logic [1:0] exp_audio;
    logic       exp_done;
  } vec_t;

  vec_t vecs [15];
  int   exp_edges [6];
  int   n_changes;
  int   n_done;
  int   n_bad;
  int   tog0;
  int   tog1;
  int   mix_ones;
  int   pop_sum;
  logic [ADDR_W-1:0] last_step;
  logic [1:0]        last_audio;

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .VOICES(VOICES), .PERIOD_W(PERIOD_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .play(play), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .step_index(step_index), .done(done),
    .audio_out(audio_out), .audio_mix(audio_mix), .aud_sd(aud_sd)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic l);
    play    = p;
    loop_en = l;
  endtask

  task automatic runTo(input int k);
    while (edge_no < k) begin
      @(posedge clock);
      #1;
      edge_no++;
    end
  endtask

  task automatic writeEntry(input int a, input logic e, input logic [4:0] d,
                            input logic [7:0] h1, input logic [7:0] h0);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = {e, d, h1, h0};
    @(posedge clock);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic startSong(input logic l);
    applyStimulus(1'b1, l);
    edge_no = 0;
  endtask

  task automatic stopSong;
    applyStimulus(1'b0, 1'b0);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // edge, play, loop, busy, step, audio, done
    vecs[0]  = '{1,   1'b1, 1'b0, 1'b1, 0, 2'b00, 1'b0};
    vecs[1]  = '{2,   1'b1, 1'b0, 1'b1, 0, 2'b00, 1'b0};
    vecs[2]  = '{3,   1'b1, 1'b0, 1'b1, 0, 2'b00, 1'b0};
    vecs[3]  = '{7,   1'b1, 1'b0, 1'b1, 0, 2'b00, 1'b0};
    vecs[4]  = '{8,   1'b1, 1'b0, 1'b1, 0, 2'b01, 1'b0};
    vecs[5]  = '{12,  1'b1, 1'b0, 1'b1, 0, 2'b01, 1'b0};
    vecs[6]  = '{13,  1'b1, 1'b0, 1'b1, 0, 2'b00, 1'b0};
    vecs[7]  = '{18,  1'b1, 1'b0, 1'b1, 0, 2'b01, 1'b0};
    vecs[8]  = '{202, 1'b1, 1'b0, 1'b1, 0, 2'b01, 1'b0};
    vecs[9]  = '{203, 1'b1, 1'b0, 1'b1, 1, 2'b00, 1'b0};
    vecs[10] = '{205, 1'b1, 1'b0, 1'b1, 1, 2'b00, 1'b0};
    vecs[11] = '{304, 1'b1, 1'b0, 1'b1, 1, 2'b00, 1'b0};
    vecs[12] = '{305, 1'b1, 1'b0, 1'b0, 1, 2'b00, 1'b1};
    vecs[13] = '{306, 1'b1, 1'b0, 1'b0, 1, 2'b00, 1'b0};
    vecs[14] = '{307, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0};
    exp_edges = '{203, 305, 507, 609, 811, 913};

    reset   = 1'b1;
    play    = 1'b0;
    loop_en = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset step", step_index, 0);
    checkOutput("reset audio", audio_out, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset mix", audio_mix, 0);
    checkOutput("aud_sd", aud_sd, 1);
    reset = 1'b0;

    // Two-entry song: 2 ticks of voice0 half-period 5, then a 1-tick end rest.
    writeEntry(0, 1'b0, 5'd2, 8'd0, 8'd5);
    writeEntry(1, 1'b1, 5'd1, 8'd0, 8'd0);
    edge_no = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].play, vecs[i].loop_en);
      runTo(vecs[i].edge_no);
      checkOutput($sformatf("s1[%0d] busy", i), busy, vecs[i].exp_busy);
      checkOutput($sformatf("s1[%0d] step", i), step_index, vecs[i].exp_step);
      checkOutput($sformatf("s1[%0d] audio", i), audio_out, vecs[i].exp_audio);
      checkOutput($sformatf("s1[%0d] done", i), done, vecs[i].exp_done);
`ifndef TONE_SEQ_MIX_EN
      checkOutput($sformatf("s1[%0d] mix", i), audio_mix, vecs[i].exp_audio[0]);
`endif
    end
    stopSong();

    // Looping: step_index alternates with fixed change edges and done never fires.
    startSong(1'b1);
    n_changes = 0;
    n_done    = 0;
    last_step = '0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clock);
      #1;
      edge_no++;
      if (done) n_done++;
      if (step_index != last_step) begin
        if (n_changes < 6) begin
          checkOutput($sformatf("loop change %0d edge", n_changes), edge_no, exp_edges[n_changes]);
          checkOutput($sformatf("loop change %0d step", n_changes), step_index, (n_changes % 2 == 0) ? 1 : 0);
        end
        n_changes++;
        last_step = step_index;
      end
    end
    checkOutput("loop change count", n_changes, 6);
    checkOutput("loop done pulses", n_done, 0);
    stopSong();

    // Zero-duration entry at address 1 is skipped without touching audio.
    writeEntry(0, 1'b0, 5'd1, 8'd0, 8'd3);
    writeEntry(1, 1'b0, 5'd0, 8'd0, 8'd7);
    writeEntry(2, 1'b1, 5'd1, 8'd0, 8'd0);
    startSong(1'b0);
    runTo(102);
    checkOutput("skip pre audio", audio_out, 2'b01);
    n_bad = 0;
    for (int c = 103; c <= 106; c++) begin
      runTo(c);
      if (audio_out !== 2'b01) n_bad++;
    end
    checkOutput("skip audio held", n_bad, 0);
    runTo(107);
    checkOutput("skip step", step_index, 2);
    checkOutput("skip audio start", audio_out, 2'b00);
    runTo(207);
    checkOutput("skip done", done, 1);
    checkOutput("skip end step", step_index, 2);
    stopSong();

    // Drop play mid-note, then restart from address 0.
    writeEntry(0, 1'b0, 5'd2, 8'd0, 8'd5);
    writeEntry(1, 1'b1, 5'd1, 8'd0, 8'd0);
    startSong(1'b0);
    runTo(50);
    checkOutput("stop pre audio", audio_out, 2'b01);
    applyStimulus(1'b0, 1'b0);
    runTo(51);
    checkOutput("stop busy", busy, 0);
    checkOutput("stop audio", audio_out, 0);
    checkOutput("stop step", step_index, 0);
    startSong(1'b0);
    runTo(7);
    checkOutput("restart audio7", audio_out, 2'b00);
    runTo(8);
    checkOutput("restart audio8", audio_out, 2'b01);
    checkOutput("restart step", step_index, 0);

    // Reset during PLAY clears outputs; replay shows memory survived.
    runTo(50);
    reset = 1'b1;
    runTo(51);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst audio", audio_out, 0);
    checkOutput("rst step", step_index, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst mix", audio_mix, 0);
    reset   = 1'b0;
    edge_no = 0;
    runTo(8);
    checkOutput("replay audio8", audio_out, 2'b01);
    runTo(203);
    checkOutput("replay step", step_index, 1);
    runTo(305);
    checkOutput("replay done", done, 1);
    stopSong();

    // Two voices held: toggle counts per voice and the audio_mix density.
    writeEntry(0, 1'b1, 5'd31, 8'd6, 8'd4);
    startSong(1'b0);
    runTo(3);
    checkOutput("dual start audio", audio_out, 2'b00);
    tog0       = 0;
    tog1       = 0;
    mix_ones   = 0;
    pop_sum    = 0;
    last_audio = audio_out;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clock);
      #1;
      edge_no++;
      if (audio_out[0] != last_audio[0]) tog0++;
      if (audio_out[1] != last_audio[1]) tog1++;
      last_audio = audio_out;
      pop_sum += int'(audio_out[0]) + int'(audio_out[1]);
      if (audio_mix) mix_ones++;
    end
    checkOutput("voice0 toggles", tog0, 250);
    checkOutput("voice1 toggles", tog1, 166);
    checkOutput("popcount sum", pop_sum, 998);
`ifdef TONE_SEQ_MIX_EN
    checkOutput("mix density", ((2 * mix_ones - pop_sum) <= 40 && (pop_sum - 2 * mix_ones) <= 40) ? 1 : 0, 1);
`else
    checkOutput("mix ones", mix_ones, 500);
`endif
    stopSong();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 16: duration-tick rate in Hz (tempo unit).
REQ-003 SHALL have parameter VOICES, default 2: number of simultaneous square-wave voices (1..4).
REQ-004 SHALL have parameter PERIOD_W, default 20: width of each voice half-period field, in clocks.
REQ-005 SHALL have parameter ADDR_W, default 8: song memory address width (depth 2**ADDR_W).
REQ-006 SHALL define ENTRY_W = 1 + 5 + VOICES*PERIOD_W: {end[1], dur[5], half_period[VOICES-1:0]}, with voice 0 in the LSBs.
REQ-007 SHALL have port: clock  input  1  rising-edge clock.
REQ-008 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port: play  input  1  level; 1 runs the song, 0 stops and rewinds.
REQ-010 SHALL have port: loop_en  input  1  restart at address 0 after an end entry.
REQ-011 SHALL have port: wr_en  input  1  song memory write strobe.
REQ-012 SHALL have port: wr_addr  input  ADDR_W  song memory write address.
REQ-013 SHALL have port: wr_data  input  ENTRY_W  song memory write data.
REQ-014 SHALL have port: busy  output  1  high in FETCH or PLAY.
REQ-015 SHALL have port: step_index  output  ADDR_W  address of the entry currently playing.
REQ-016 SHALL have port: done  output  1  one-cycle pulse when an end entry finishes and loop_en=0.
REQ-017 SHALL have port: audio_out  output  VOICES  per-voice square waves.
REQ-018 SHALL have port: audio_mix  output  1  mixed single-pin audio.
REQ-019 SHALL have port: aud_sd  output  1  amplifier enable, constant 1.

Function
REQ-020 SHALL implement the states IDLE, FETCH, PLAY and HOLD; the memory SHALL be synchronous-read with 1-cycle latency, and FETCH SHALL last exactly 2 cycles (address issue, then capture).
REQ-021 SHALL transition IDLE->FETCH when play=1, starting at address 0.
REQ-022 SHALL transition FETCH->PLAY when the captured entry has dur!=0.
REQ-023 SHALL treat an entry with dur==0 as zero length: it SHALL advance the address and refetch without entering PLAY, and audio SHALL not change.
REQ-024 SHALL clear the tick divider (period CLK_HZ/TICK_HZ clocks, integer division) on entry to PLAY; the note SHALL last exactly dur*(CLK_HZ/TICK_HZ) clocks.
REQ-025 SHALL, on note expiry with end=0, advance the address and go to FETCH; address wrap from 2**ADDR_W-1 to 0 SHALL be silent.
REQ-026 SHALL, on note expiry with end=1, go to FETCH at address 0 if loop_en=1, or pulse done, silence all voices and go to HOLD if loop_en=0.
REQ-027 SHALL transition HOLD->IDLE when play=0.
REQ-028 SHALL, when play=0 in any state, go to IDLE within 1 cycle with address 0 and audio_out=0.
REQ-029 SHALL, per voice v, count to half_period[v]-1 and then toggle audio_out[v] and clear the counter; the counter SHALL be cleared and audio_out[v]=0 at each note start.
REQ-030 SHALL treat half_period[v]==0 as a rest: audio_out[v] held at 0.
REQ-031 SHALL hold audio_out during FETCH, adding a 2-cycle gap between notes.
REQ-032 SHALL accept wr_en in every state; a write to the address being fetched in the same cycle SHALL return the old data.

Reset
REQ-033 SHALL, on reset, set state=IDLE, address=0, all counters=0, audio_out=0, audio_mix=0, done=0, busy=0 and step_index=0.
REQ-034 SHALL leave song memory contents unaffected by reset.

Configuration
REQ-035 SHALL, with TONE_SEQ_MIX_EN defined, drive audio_mix from a first-order sigma-delta modulator whose input is the popcount of audio_out scaled to full range (accumulator width clog2(VOICES)+1), so that audio_mix density equals active_voices/VOICES.
REQ-036 SHALL, with TONE_SEQ_MIX_EN undefined, drive audio_mix = audio_out[0] and contain no mixer logic.

Verification (CLK_HZ=1600, TICK_HZ=16 -> 100 clocks/tick, VOICES=2, PERIOD_W=8)
REQ-037 SHALL cover: write entry0={0,2,v1=0,v0=5} and entry1={1,1,0,0}, play=1 -> audio_out[0] toggles every 5 clocks for 200 clocks, rest for 100 clocks, done pulses once, state HOLD.
REQ-038 SHALL cover: same song with loop_en=1 -> step_index sequence 0,1,0,1,... and done never asserted.
REQ-039 SHALL cover: entry with dur=0 at address 1 -> step_index goes 0 to 2, no audio activity at address 1.
REQ-040 SHALL cover: play dropped mid-note -> busy=0 and audio_out=0 on the next cycle; play re-raised -> restarts at address 0.
REQ-041 SHALL cover: reset asserted during PLAY -> all outputs 0 the next cycle; memory contents intact on replay.
REQ-042 SHALL cover: with TONE_SEQ_MIX_EN, v0=4 and v1=6 held -> audio_mix high-density averaged over 1000 clocks within +/-2% of mean(popcount)/2.
